// File: rtl/filt_oup_decim_if.sv
// ---------------------------------------------------------------------------
// filt_oup_decim_if
//
// Purpose: groups the stream signals of filt_oup_decim. The input side carries
// the full-precision filt_mac result. The output side carries the narrow
// valid/ready stream and the status flags.
//
// Signals:
//   i_ena    capture enable
//   i_data   filter result, gp_inp_width bits, two's complement
//   i_done   result-ready indication, as a pulse or a level
//   o_data   head of the output FIFO, gp_oup_width bits
//   o_valid  output FIFO is non-empty
//   i_ready  consumer accepts o_data
//   o_sat    one-cycle pulse when a kept sample was clipped
//   o_ovf    sticky flag: a kept sample was dropped on a full FIFO
//
// Modports:
//   master   producer/consumer side (drives i_*, observes o_*)
//   slave    filt_oup_decim side (observes i_*, drives o_*)
// ---------------------------------------------------------------------------
interface filt_oup_decim_if #(
    parameter int gp_inp_width = 32,
    parameter int gp_oup_width = 16
);
    logic                    i_ena;
    logic [gp_inp_width-1:0] i_data;
    logic                    i_done;
    logic [gp_oup_width-1:0] o_data;
    logic                    o_valid;
    logic                    i_ready;
    logic                    o_sat;
    logic                    o_ovf;

    modport master (
        output i_ena, i_data, i_done, i_ready,
        input  o_data, o_valid, o_sat, o_ovf
    );

    modport slave (
        input  i_ena, i_data, i_done, i_ready,
        output o_data, o_valid, o_sat, o_ovf
    );
endinterface

// File: rtl/filt_oup_decim.sv
// ---------------------------------------------------------------------------
// filt_oup_decim
//
// Purpose: this block sits downstream of filt_mac. It processes each result
// through this chain:
//   1. Detect the rising edge of i_done.
//   2. Keep every gp_decim-th captured result.
//   3. Scale the kept result with an arithmetic right shift.
//   4. Saturate it to gp_oup_width bits.
//   5. Queue it in a small FIFO that a valid/ready consumer drains.
//
// Ports:
//   i_clk     system clock (shared with filt_mac)
//   i_rst_an  asynchronous active-low reset
//   bus       filt_oup_decim_if.slave: i_ena, i_data, i_done, i_ready inputs;
//             o_data, o_valid, o_sat, o_ovf outputs
//
// Optional feature:
//   FILT_OUP_DECIM_ROUND_EN  When defined, the block adds 2^(gp_shift-1)
//                            before the shift, which rounds half up.
//                            When undefined, the shift simply truncates.
//                            Latency is the same in both builds.
// ---------------------------------------------------------------------------
module filt_oup_decim #(
    parameter int gp_inp_width  = 32,
    parameter int gp_oup_width  = 16,
    parameter int gp_shift      = 8,
    parameter int gp_decim      = 4,
    parameter int gp_fifo_depth = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_an,
    filt_oup_decim_if.slave  bus
);
    localparam int lp_cnt_w = (gp_decim > 1) ? $clog2(gp_decim) : 1;
    localparam int lp_ptr_w = $clog2(gp_fifo_depth);
    localparam int lp_sum_w = gp_inp_width + 1;

    localparam logic [lp_cnt_w-1:0] lp_cnt_last = lp_cnt_w'(gp_decim - 1);
    localparam logic [lp_ptr_w:0]   lp_full     = (lp_ptr_w + 1)'(gp_fifo_depth);

    // The clip bounds are sign-extended to the working width so the
    // comparisons below are plain signed compares.
    localparam logic signed [lp_sum_w-1:0] lp_sat_max =
        (lp_sum_w'(1) << (gp_oup_width - 1)) - lp_sum_w'(1);
    localparam logic signed [lp_sum_w-1:0] lp_sat_min = ~lp_sat_max;

    logic                        done_q;
    logic [lp_cnt_w-1:0]         dec_cnt;
    logic                        capture;
    logic                        keep;
    logic signed [lp_sum_w-1:0]  sum_ext;
    logic signed [lp_sum_w-1:0]  shifted;
    logic                        clip_hi;
    logic                        clip_lo;
    logic [gp_oup_width-1:0]     sat_data;

    logic                        s1_valid;
    logic [gp_oup_width-1:0]     s1_data;
    logic                        sat_q;

    logic [gp_oup_width-1:0]     mem [gp_fifo_depth];
    logic [lp_ptr_w-1:0]         wr_ptr;
    logic [lp_ptr_w-1:0]         rd_ptr;
    logic [lp_ptr_w:0]           count;
    logic                        ovf_q;
    logic                        fifo_valid;
    logic                        pop;
    logic                        full;
    logic                        wr_accept;

    // A capture happens only on the rising edge of i_done. This way a
    // level-style done still produces exactly one capture.
    assign capture = bus.i_done & ~done_q & bus.i_ena;
    assign keep    = capture & (dec_cnt == '0);

`ifdef FILT_OUP_DECIM_ROUND_EN
    // The shift amount is forced to 0 when gp_shift is 0. That keeps the
    // dead branch legal during elaboration; its value is never used.
    localparam logic signed [lp_sum_w-1:0] lp_round =
        (gp_shift == 0) ? '0 : (lp_sum_w'(1) << ((gp_shift == 0) ? 0 : gp_shift - 1));
    assign sum_ext = $signed({bus.i_data[gp_inp_width-1], bus.i_data}) + lp_round;
`else
    assign sum_ext = $signed({bus.i_data[gp_inp_width-1], bus.i_data});
`endif

    assign shifted  = sum_ext >>> gp_shift;
    assign clip_hi  = shifted > lp_sat_max;
    assign clip_lo  = shifted < lp_sat_min;
    assign sat_data = clip_hi ? lp_sat_max[gp_oup_width-1:0] :
                      clip_lo ? lp_sat_min[gp_oup_width-1:0] :
                                shifted[gp_oup_width-1:0];

    // Edge-detect register and decimation counter. The counter advances
    // only on real captures, so it freezes while i_ena is low.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            done_q  <= 1'b0;
            dec_cnt <= '0;
        end else begin
            done_q <= bus.i_done;
            if (capture) begin
                dec_cnt <= (dec_cnt == lp_cnt_last) ? '0 : dec_cnt + 1'b1;
            end
        end
    end

    // Stage 1 holds the scaled and saturated sample. The o_sat flag is
    // registered alongside it, so it is high in the same cycle as the sample.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            sat_q    <= 1'b0;
        end else begin
            s1_valid <= keep;
            s1_data  <= sat_data;
            sat_q    <= keep & (clip_hi | clip_lo);
        end
    end

    assign fifo_valid = (count != '0);
    assign pop        = fifo_valid & bus.i_ready;
    assign full       = (count == lp_full);
    // When the FIFO is full, a write still goes in if a pop frees a slot
    // on the same edge.
    assign wr_accept  = s1_valid & (~full | pop);

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_accept && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_accept && pop) begin
                count <= count - 1'b1;
            end
            if (s1_valid && !wr_accept) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset. Reads are masked by fifo_valid, so stale
    // contents are never visible.
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= s1_data;
        end
    end

    assign bus.o_valid = fifo_valid;
    assign bus.o_data  = fifo_valid ? mem[rd_ptr] : '0;
    assign bus.o_sat   = sat_q;
    assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_filt_oup_decim.sv
// ---------------------------------------------------------------------------
// tb_filt_oup_decim
//
// Purpose: directed testbench for filt_oup_decim. It instantiates two copies
// of the block:
//   dut1  gp_decim=1; covers latency, saturation, overflow and level-style
//         done.
//   dut4  gp_decim=4; covers decimation and the freeze while i_ena is low.
// Both use gp_shift=8, gp_fifo_depth=4, a 32-bit input and a 16-bit output.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_filt_oup_decim;
    logic        clk = 1'b0;
    logic        rst_n;

    logic        ena1, done1, ready1;
    logic [31:0] data1;
    logic        ena4, done4, ready4;
    logic [31:0] data4;

    int          checks   = 0;
    int          failures = 0;

    logic [15:0] out4_q[$];
    logic        mon4_en = 1'b0;

`ifdef FILT_OUP_DECIM_ROUND_EN
    localparam logic [15:0] exp_t1 = 16'h0013;
`else
    localparam logic [15:0] exp_t1 = 16'h0012;
`endif

    filt_oup_decim_if #(.gp_inp_width(32), .gp_oup_width(16)) bus1 ();
    filt_oup_decim_if #(.gp_inp_width(32), .gp_oup_width(16)) bus4 ();

    assign bus1.i_ena   = ena1;
    assign bus1.i_done  = done1;
    assign bus1.i_data  = data1;
    assign bus1.i_ready = ready1;
    assign bus4.i_ena   = ena4;
    assign bus4.i_done  = done4;
    assign bus4.i_data  = data4;
    assign bus4.i_ready = ready4;

    filt_oup_decim #(
        .gp_inp_width(32), .gp_oup_width(16), .gp_shift(8),
        .gp_decim(1), .gp_fifo_depth(4)
    ) dut1 (
        .i_clk(clk), .i_rst_an(rst_n), .bus(bus1)
    );

    filt_oup_decim #(
        .gp_inp_width(32), .gp_oup_width(16), .gp_shift(8),
        .gp_decim(4), .gp_fifo_depth(4)
    ) dut4 (
        .i_clk(clk), .i_rst_an(rst_n), .bus(bus4)
    );

    always #5 clk = ~clk;

    // Record every word dut4 hands over. The sample is taken on the
    // falling edge, ahead of the rising edge that pops the word.
    always @(negedge clk) begin
        if (mon4_en && bus4.o_valid && ready4) begin
            out4_q.push_back(bus4.o_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Raise i_done on the selected DUTs for one cycle. On return, the
    // capture edge has just passed.
    task automatic applyStimulus(input logic [31:0] data, input logic to1, input logic to4);
        if (to1) begin
            data1 = data;
            done1 = 1'b1;
        end
        if (to4) begin
            data4 = data;
            done4 = 1'b1;
        end
        tick();
        done1 = 1'b0;
        done4 = 1'b0;
    endtask

    task automatic pop1();
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
    endtask

    initial begin
        logic [31:0] sat_in  [3] = '{32'h7FFF_FF00, 32'h8000_0000, 32'h0000_0100};
        logic [15:0] sat_exp [3] = '{16'h7FFF, 16'h8000, 16'h0001};
        logic        sat_flag[3] = '{1'b1, 1'b1, 1'b0};

        rst_n  = 1'b0;
        ena1   = 1'b1; done1 = 1'b0; ready1 = 1'b0; data1 = '0;
        ena4   = 1'b1; done4 = 1'b0; ready4 = 1'b0; data4 = '0;
        #2;
        checkOutput("rst_valid1", {31'd0, bus1.o_valid}, 32'd0);
        checkOutput("rst_data1",  {16'd0, bus1.o_data},  32'd0);
        checkOutput("rst_sat1",   {31'd0, bus1.o_sat},   32'd0);
        checkOutput("rst_ovf1",   {31'd0, bus1.o_ovf},   32'd0);
        checkOutput("rst_valid4", {31'd0, bus4.o_valid}, 32'd0);
        checkOutput("rst_data4",  {16'd0, bus4.o_data},  32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] basic latency and scaling");
        applyStimulus(32'h0000_12C0, 1'b1, 1'b0);
        checkOutput("t1_valid_cyc1", {31'd0, bus1.o_valid}, 32'd0);
        tick();
        checkOutput("t1_valid_cyc2", {31'd0, bus1.o_valid}, 32'd1);
        checkOutput("t1_data",       {16'd0, bus1.o_data},  {16'd0, exp_t1});
        pop1();
        checkOutput("t1_empty",      {31'd0, bus1.o_valid}, 32'd0);

        $display("[TB] saturation");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(sat_in[i], 1'b1, 1'b0);
            checkOutput($sformatf("t2_sat_%0d", i), {31'd0, bus1.o_sat}, {31'd0, sat_flag[i]});
            tick();
            checkOutput($sformatf("t2_sat_end_%0d", i), {31'd0, bus1.o_sat}, 32'd0);
            checkOutput($sformatf("t2_data_%0d", i), {16'd0, bus1.o_data}, {16'd0, sat_exp[i]});
            pop1();
        end

        $display("[TB] overflow");
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(32'(k) << 8, 1'b1, 1'b0);
            tick();
            if (k == 4) begin
                checkOutput("t4_ovf_before", {31'd0, bus1.o_ovf}, 32'd0);
            end
        end
        checkOutput("t4_ovf_set", {31'd0, bus1.o_ovf},   32'd1);
        checkOutput("t4_valid",   {31'd0, bus1.o_valid}, 32'd1);
        checkOutput("t4_head",    {16'd0, bus1.o_data},  32'd1);
        ready1 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("t4_pop_%0d", i), {16'd0, bus1.o_data}, 32'(i));
            tick();
        end
        ready1 = 1'b0;
        checkOutput("t4_drained", {31'd0, bus1.o_valid}, 32'd0);
        checkOutput("t4_ovf_sticky", {31'd0, bus1.o_ovf}, 32'd1);

        $display("[TB] level-style done");
        data1 = 32'h0000_0300;
        done1 = 1'b1;
        repeat (3) tick();
        done1 = 1'b0;
        repeat (2) tick();
        data1 = 32'h0000_0400;
        done1 = 1'b1;
        repeat (3) tick();
        done1 = 1'b0;
        repeat (3) tick();
        checkOutput("t5_first",  {16'd0, bus1.o_data}, 32'h3);
        pop1();
        checkOutput("t5_second_valid", {31'd0, bus1.o_valid}, 32'd1);
        checkOutput("t5_second", {16'd0, bus1.o_data}, 32'h4);
        pop1();
        checkOutput("t5_only_two", {31'd0, bus1.o_valid}, 32'd0);

        $display("[TB] decimation by 4");
        ready4  = 1'b1;
        mon4_en = 1'b1;
        out4_q.delete();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(32'(k) << 8, 1'b0, 1'b1);
            tick();
        end
        repeat (4) tick();
        checkOutput("t3_count", 32'(out4_q.size()), 32'd2);
        checkOutput("t3_out0", {16'd0, (out4_q.size() > 0) ? out4_q[0] : 16'hFFFF}, 32'h1);
        checkOutput("t3_out1", {16'd0, (out4_q.size() > 1) ? out4_q[1] : 16'hFFFF}, 32'h5);

        $display("[TB] enable freeze");
        out4_q.delete();
        applyStimulus(32'h0000_0900, 1'b0, 1'b1);
        tick();
        ena4 = 1'b0;
        for (int k = 10; k <= 12; k++) begin
            applyStimulus(32'(k) << 8, 1'b0, 1'b1);
            tick();
        end
        ena4 = 1'b1;
        for (int k = 13; k <= 16; k++) begin
            applyStimulus(32'(k) << 8, 1'b0, 1'b1);
            tick();
        end
        repeat (4) tick();
        checkOutput("t5_ena_count", 32'(out4_q.size()), 32'd2);
        checkOutput("t5_ena_out0", {16'd0, (out4_q.size() > 0) ? out4_q[0] : 16'hFFFF}, 32'h9);
        checkOutput("t5_ena_out1", {16'd0, (out4_q.size() > 1) ? out4_q[1] : 16'hFFFF}, 32'h10);

        $display("[TB] reset mid-stream");
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(32'(k) << 8, 1'b1, 1'b0);
            tick();
        end
        applyStimulus(32'h0000_0400, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_valid1", {31'd0, bus1.o_valid}, 32'd0);
        checkOutput("t6_data1",  {16'd0, bus1.o_data},  32'd0);
        checkOutput("t6_sat1",   {31'd0, bus1.o_sat},   32'd0);
        checkOutput("t6_ovf1",   {31'd0, bus1.o_ovf},   32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("t6_no_stale", {31'd0, bus1.o_valid}, 32'd0);
        out4_q.delete();
        applyStimulus(32'h0000_0700, 1'b1, 1'b1);
        checkOutput("t6_lat_cyc1", {31'd0, bus1.o_valid}, 32'd0);
        tick();
        checkOutput("t6_lat_cyc2", {31'd0, bus1.o_valid}, 32'd1);
        checkOutput("t6_data",     {16'd0, bus1.o_data},  32'h7);
        repeat (3) tick();
        checkOutput("t6_dec_count", 32'(out4_q.size()), 32'd1);
        checkOutput("t6_dec_out0", {16'd0, (out4_q.size() > 0) ? out4_q[0] : 16'hFFFF}, 32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/filt_oup_decim.md
Name: filt_oup_decim

Overview:
- Downstream stage of filt_mac. It consumes the full-precision o_data/o_done stream and produces a narrow output stream for the next block.
- Processing chain: keep every gp_decim-th filter result, scale by an arithmetic right shift, saturate to the output width, then buffer in a small FIFO.
- Output side uses a valid/ready handshake, so a slow consumer can stall without disturbing filt_mac timing.
- Flags report saturation and FIFO overflow.

Parameters:
- gp_inp_width, 32: width of i_data (two's complement); must equal the filt_mac gp_oup_width.
- gp_oup_width, 16: width of o_data (two's complement); must be less than gp_inp_width - gp_shift + 1.
- gp_shift, 8: number of LSBs discarded; 0 means no scaling.
- gp_decim, 4: decimation factor; 1 means keep every sample.
- gp_fifo_depth, 4: FIFO entries; power of two, at least 2.

Ports:
- i_clk  in  1  system clock (same clock as filt_mac).
- i_rst_an  in  1  asynchronous active-low reset.
- i_ena  in  1  capture enable.
- i_data  in  gp_inp_width  filter result (filt_mac o_data).
- i_done  in  1  result-ready indication (filt_mac o_done), pulse or level.
- o_data  out  gp_oup_width  head of FIFO.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accepts o_data.
- o_sat  out  1  one-cycle pulse when a kept sample was clipped.
- o_ovf  out  1  sticky flag: a kept sample was dropped because the FIFO was full.

Behaviour:
- Reset (async, i_rst_an=0):
  - o_data=0, o_valid=0, o_sat=0, o_ovf=0.
  - Decimation counter=0, FIFO pointers and count=0, done_q=0, pipeline valid=0.
- Edge detect:
  - done_q registers i_done every cycle.
  - Capture event = i_done & ~done_q & i_ena, so exactly one capture per rising edge of i_done regardless of pulse length.
  - i_done high out of reset counts as an edge.
- Decimation:
  - Counter runs 0..gp_decim-1 and advances only on capture events, wrapping to 0.
  - A sample is kept when the counter is 0, so the first capture after reset is kept.
  - i_ena=0 freezes the counter; the FIFO still drains.
- Stage 1 (registered on the cycle after capture):
  - s = i_data >>> gp_shift (arithmetic shift).
  - If s > 2^(gp_oup_width-1)-1, s becomes the max positive value; if s < -2^(gp_oup_width-1), s becomes the min negative value.
  - o_sat pulses high in this same cycle when clipping occurred.
- Stage 2: FIFO write on the next clock edge.
  - o_valid rises 2 cycles after the capture cycle when the FIFO was empty.
  - Total latency: capture at edge N, stage 1 at N+1, o_valid=1 after edge N+2.
- Read:
  - Pop when o_valid & i_ready at a clock edge.
  - o_data = mem[rd_ptr] when o_valid=1, else 0.
  - o_data is stable while o_valid=1 and i_ready=0.
- Full:
  - A write arriving with count==gp_fifo_depth and no simultaneous pop is dropped and o_ovf is set.
  - o_ovf stays set until reset.
  - Write together with a pop while full: both occur, count unchanged, no overflow.
- Empty: a pop with o_valid=0 is ignored; count never underflows.
- Pointers wrap modulo gp_fifo_depth.
- Reset mid-operation clears all state immediately, including an in-flight stage 1 sample.

Optional Feature:
- Macro: FILT_OUP_DECIM_ROUND_EN.
- Defined: round half up before the shift. Add 2^(gp_shift-1) to i_data in a sign-extended gp_inp_width+1 bit sum, then shift, then saturate. Requires gp_shift of at least 1; at gp_shift=0 the rounding has no effect.
- Undefined: plain truncation, no adder.
- Latency is identical in both builds.

Test Plan:
1. gp_decim=1, i_data=0x000012C0, one i_done pulse:
   - Without macro: o_data=0x0012.
   - With macro: o_data=0x0013.
   - In both builds o_valid rises 2 cycles after capture.
2. Saturation, gp_decim=1:
   - i_data=0x7FFFFF00 gives o_data=0x7FFF with o_sat=1 for one cycle.
   - i_data=0x80000000 gives o_data=0x8000 with o_sat=1.
   - i_data=0x00000100 gives o_data=0x0001 with o_sat=0.
3. Decimation, gp_decim=4, i_ready=1: inputs k*256 for k=1..8 must yield exactly 2 outputs, 0x0001 and 0x0005.
4. Overflow, gp_decim=1, gp_fifo_depth=4, i_ready=0, five kept samples 1..5 (×256):
   - o_ovf=1 after the fifth write and o_valid stays 1.
   - Then raising i_ready pops 1,2,3,4 on consecutive cycles, after which o_valid=0.
   - o_ovf remains 1.
5. i_done held high for 3 cycles, then low for 2 cycles, then high again: exactly 2 captures. i_done pulses while i_ena=0: no captures and the counter is unchanged.
6. Reset mid-stream: assert i_rst_an=0 with 3 entries queued and one sample in stage 1. Outputs must clear asynchronously. After release, the first new capture is kept (counter at 0) and appears with 2-cycle latency.
